// File: rtl/nibble_dmem_arbiter.sv
// rtl/nibble_dmem_arbiter.sv - CPU/host data memory arbiter with host starvation guard; optional host lock via NIBBLE_ARB_LOCK_EN
module nibble_dmem_arbiter #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 4,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
`ifdef NIBBLE_ARB_LOCK_EN
   input  logic              h_lock,
`endif
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_C = 2'd1,
      GNT_H = 2'd2
   } state_t;

   localparam logic [2:0] C_MAX_WAIT = MAX_WAIT[2:0];

   state_t            r_state;
   state_t            w_next_state;
   logic [2:0]        r_wait_cnt;
   logic [2:0]        w_wait_nxt;
   logic              w_lock_hold;
   logic              r_c_rvalid;
   logic              r_h_rvalid;
   logic [DATA_W-1:0] r_c_rdata;
   logic [DATA_W-1:0] r_h_rdata;
   logic              w_c_rd_done;
   logic              w_h_rd_done;

   // State and starvation counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= 3'd0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Next-state decision: C wins ties unless H has waited MAX_WAIT cycles
   always_comb begin
      w_next_state = IDLE;
      w_lock_hold  = 1'b0;
`ifdef NIBBLE_ARB_LOCK_EN
      w_lock_hold  = (r_state == GNT_H) && h_lock && h_req;
`endif
      if (w_lock_hold) begin
         w_next_state = GNT_H;
      end else if (c_req && h_req) begin
         w_next_state = (r_wait_cnt == C_MAX_WAIT) ? GNT_H : GNT_C;
      end else if (c_req) begin
         w_next_state = GNT_C;
      end else if (h_req) begin
         w_next_state = GNT_H;
      end
   end

   // Host wait counter: counts lost arbitrations, saturates, clears on host grant or idle host
   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (!h_req || (w_next_state == GNT_H)) begin
         w_wait_nxt = 3'd0;
      end else if ((w_next_state == GNT_C) && (r_wait_cnt != C_MAX_WAIT)) begin
         w_wait_nxt = r_wait_cnt + 3'd1;
      end
   end

   // Memory drive follows the current owner's live request fields
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      case (r_state)
         GNT_C: begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_write = c_we;
         end
         GNT_H: begin
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            mem_write = h_we;
         end
         default: begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_write = 1'b0;
         end
      endcase
   end

   assign w_c_rd_done = (r_state == GNT_C) && !c_we;
   assign w_h_rd_done = (r_state == GNT_H) && !h_we;

   // Read return: capture memory data at the edge closing a read grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_c_rvalid <= 1'b0;
         r_h_rvalid <= 1'b0;
         r_c_rdata  <= '0;
         r_h_rdata  <= '0;
      end else begin
         r_c_rvalid <= w_c_rd_done;
         r_h_rvalid <= w_h_rd_done;
         if (w_c_rd_done) begin
            r_c_rdata <= mem_rdata;
         end
         if (w_h_rd_done) begin
            r_h_rdata <= mem_rdata;
         end
      end
   end

   assign c_gnt    = (r_state == GNT_C);
   assign h_gnt    = (r_state == GNT_H);
   assign c_rvalid = r_c_rvalid;
   assign h_rvalid = r_h_rvalid;
   assign c_rdata  = r_c_rdata;
   assign h_rdata  = r_h_rdata;

endmodule

// File: tb/tb_nibble_dmem_arbiter.sv
// tb/tb_nibble_dmem_arbiter.sv - directed self-checking bench for nibble_dmem_arbiter
module tb_nibble_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_req, c_we;
   logic [3:0] c_addr, c_wdata, c_rdata;
   logic       c_gnt, c_rvalid;
   logic       h_req, h_we;
   logic [3:0] h_addr, h_wdata, h_rdata;
   logic       h_gnt, h_rvalid;
`ifdef NIBBLE_ARB_LOCK_EN
   logic       h_lock;
`endif
   logic [3:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_write;

   logic [3:0] mem [16] = '{default: 4'h0};
   logic       pre_en = 1'b0;
   logic [3:0] pre_addr = 4'h0;
   logic [3:0] pre_data = 4'h0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_write) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   nibble_dmem_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_WAIT(3)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
`ifdef NIBBLE_ARB_LOCK_EN
      .h_lock(h_lock),
`endif
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] a, input logic [3:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      step();
      pre_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
`ifdef NIBBLE_ARB_LOCK_EN
      h_lock = 0;
`endif
      step(); step();
      n_cmp++;
      if ({c_gnt, h_gnt, c_rvalid, h_rvalid, mem_write} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_held_ctl: got %b want 00000", {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_write});
      end
      n_cmp++;
      if ({c_rdata, h_rdata, mem_addr, mem_wdata} !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_held_data: got %h want 0000", {c_rdata, h_rdata, mem_addr, mem_wdata});
      end
      reset = 1'b0;
      step(); step();
      n_cmp++;
      if ({c_gnt, h_gnt, c_rvalid, h_rvalid, mem_write} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_release_ctl: got %b want 00000", {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_write});
      end
   endtask

   task automatic test_cpu_read();
      preload(4'h5, 4'hA);
      c_req = 1; c_we = 0; c_addr = 4'h5;
      step();
      n_cmp++;
      if ({c_gnt, h_gnt, mem_write, mem_addr} !== {3'b100, 4'h5}) begin
         n_bad++;
         $display("FAIL cpu_read_gnt: got gnt_c/gnt_h/wr/addr=%b want 1000101", {c_gnt, h_gnt, mem_write, mem_addr});
      end
      c_req = 0;
      step();
      n_cmp++;
      if ({c_rvalid, c_rdata, c_gnt, h_rvalid} !== {1'b1, 4'hA, 2'b00}) begin
         n_bad++;
         $display("FAIL cpu_read_data: got rvalid=%b rdata=%h gnt=%b h_rvalid=%b want 1 a 0 0", c_rvalid, c_rdata, c_gnt, h_rvalid);
      end
      step();
      n_cmp++;
      if ({c_rvalid, c_rdata} !== {1'b0, 4'hA}) begin
         n_bad++;
         $display("FAIL cpu_read_hold: got rvalid=%b rdata=%h want 0 a", c_rvalid, c_rdata);
      end
   endtask

   task automatic test_starvation();
      logic exp_c;
      c_req = 1; c_we = 0; c_addr = 4'h5;
      h_req = 1; h_we = 0; h_addr = 4'h1;
      for (int i = 0; i < 8; i++) begin
         step();
         exp_c = ((i % 4) != 3);
         n_cmp++;
         if ({c_gnt, h_gnt} !== {exp_c, ~exp_c}) begin
            n_bad++;
            $display("FAIL starve_pattern[%0d]: got c/h=%b%b want %b%b", i, c_gnt, h_gnt, exp_c, ~exp_c);
         end
      end
      c_req = 0; h_req = 0;
      step(); step();
   endtask

   task automatic test_host_write_read();
      h_req = 1; h_we = 1; h_addr = 4'h2; h_wdata = 4'h7;
      step();
      n_cmp++;
      if ({h_gnt, c_gnt, mem_write, mem_addr, mem_wdata} !== {3'b101, 4'h2, 4'h7}) begin
         n_bad++;
         $display("FAIL host_write_drive: got %b want 10100100111", {h_gnt, c_gnt, mem_write, mem_addr, mem_wdata});
      end
      step();
      h_we = 0;
      n_cmp++;
      if ({h_gnt, h_rvalid} !== 2'b10) begin
         n_bad++;
         $display("FAIL host_b2b_gnt: got gnt/rvalid=%b%b want 10", h_gnt, h_rvalid);
      end
      h_req = 0;
      step();
      n_cmp++;
      if ({h_rvalid, h_rdata, c_rvalid} !== {1'b1, 4'h7, 1'b0}) begin
         n_bad++;
         $display("FAIL host_read_data: got rvalid=%b rdata=%h c_rvalid=%b want 1 7 0", h_rvalid, h_rdata, c_rvalid);
      end
      step();
   endtask

   task automatic test_reset_mid_write();
      preload(4'h9, 4'h3);
      c_req = 1; c_we = 1; c_addr = 4'h9; c_wdata = 4'hE;
      step();
      n_cmp++;
      if ({c_gnt, mem_write} !== 2'b11) begin
         n_bad++;
         $display("FAIL midrst_pre: got gnt/wr=%b%b want 11", c_gnt, mem_write);
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({c_gnt, mem_write, mem_addr} !== 6'b0) begin
         n_bad++;
         $display("FAIL midrst_async: got gnt/wr/addr=%b want 000000", {c_gnt, mem_write, mem_addr});
      end
      c_req = 0; c_we = 0;
      step();
      reset = 1'b0;
      step();
      n_cmp++;
      if (mem[9] !== 4'h3) begin
         n_bad++;
         $display("FAIL midrst_mem: got %h want 3", mem[9]);
      end
      n_cmp++;
      if ({c_gnt, c_rdata, h_rdata} !== 9'b0) begin
         n_bad++;
         $display("FAIL midrst_after: got gnt=%b c_rdata=%h h_rdata=%h want 0 0 0", c_gnt, c_rdata, h_rdata);
      end
   endtask

`ifdef NIBBLE_ARB_LOCK_EN
   task automatic test_lock();
      h_req = 1; h_we = 0; h_addr = 4'h2; h_lock = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         c_req = 1; c_we = 0; c_addr = 4'h5;
         n_cmp++;
         if ({h_gnt, c_gnt} !== 2'b10) begin
            n_bad++;
            $display("FAIL lock_hold[%0d]: got h/c=%b%b want 10", i, h_gnt, c_gnt);
         end
      end
      h_lock = 0;
      step();
      n_cmp++;
      if ({h_gnt, c_gnt} !== 2'b01) begin
         n_bad++;
         $display("FAIL lock_release: got h/c=%b%b want 01", h_gnt, c_gnt);
      end
      c_req = 0; h_req = 0;
      step(); step();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cpu_read();
      test_starvation();
      test_host_write_read();
      test_reset_mid_write();
`ifdef NIBBLE_ARB_LOCK_EN
      test_lock();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
